// File: rtl/video_crc_pkg.sv
// Shared constants, FSM state type and the bit-serial CRC-32 helper for the
// video stream CRC monitor.
package video_crc_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam int unsigned CRC_MAX_BITS = 64;
  localparam int unsigned CRC_IDX_W    = $clog2(CRC_MAX_BITS);

  typedef enum logic {
    IDLE,
    ACTIVE
  } mon_state_t;

  // MSB-first over the low nbits of data; no reflection, no final XOR.
  function automatic logic [31:0] crc32_update(input logic [31:0]             crc,
                                               input logic [CRC_MAX_BITS-1:0] data,
                                               input int unsigned             nbits);
    logic [31:0]          c;
    logic                 fb;
    logic [CRC_IDX_W-1:0] idx;
    c = crc;
    for (int unsigned k = 0; k < CRC_MAX_BITS; k++) begin
      if (k < nbits) begin
        idx = CRC_IDX_W'(nbits - 1 - k);
        fb  = c[31] ^ data[idx];
        c   = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : '0);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/video_crc32_lane.sv
// One CRC-32 lane: seeds from CRC32_INIT on init, folds data on update,
// holds otherwise. crc_next is the value the register takes on this beat.
module video_crc32_lane
  import video_crc_pkg::*;
#(
  parameter int unsigned CH_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            init,
  input  logic            update,
  input  logic [CH_W-1:0] data,
  output logic [31:0]     crc_next
);

  logic [31:0] crc_q;

  always_comb begin
    crc_next = crc32_update(init ? CRC32_INIT : crc_q, CRC_MAX_BITS'(data), CH_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else if (clr) begin
      crc_q <= '0;
    end else if (init || update) begin
      crc_q <= crc_next;
    end
  end

endmodule

// File: rtl/video_stream_crc_monitor.sv
// Passive AXI-Stream video tap: per-channel frame CRC-32, geometry checking,
// golden compare and cross-frame CRC stability tracking.
module video_stream_crc_monitor
  import video_crc_pkg::*;
#(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DIM_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  cfg_enable,
  input  logic [DIM_W-1:0]      cfg_width,
  input  logic [DIM_W-1:0]      cfg_height,
  input  logic [CHANNELS*32-1:0] cfg_golden,
  input  logic                  cfg_golden_en,
  input  logic                  clear,
  output logic [CHANNELS*32-1:0] crc_last,
  output logic                  crc_valid,
  output logic [31:0]           frame_count,
  output logic [DIM_W-1:0]      line_count,
  output logic [DIM_W-1:0]      pixel_in_line,
  output logic [15:0]           stable_count,
  output logic [15:0]           mismatch_count,
  output logic                  golden_mismatch,
  output logic                  err_sof_early,
  output logic                  err_eol_early,
  output logic                  err_eol_late
);

  localparam int unsigned CH_W = DATA_W / CHANNELS;

  mon_state_t              state_q, state_d;
  logic [DIM_W-1:0]        width_q, height_q, line_q, pix_q, line_d, pix_d;
  logic [DIM_W-1:0]        cur_w, cur_h, base_pix, base_line;
  logic [DIM_W:0]          pix_inc;
  logic                    beat, proceed, lane_init, lane_update, latch_cfg;
  logic                    frame_done, set_sof, set_early, set_late;
  logic [CHANNELS*32-1:0]  crc_next_all;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    video_crc32_lane #(.CH_W(CH_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clear),
      .init     (lane_init),
      .update   (lane_update),
      .data     (s_axis_tdata[g*CH_W +: CH_W]),
      .crc_next (crc_next_all[g*32 +: 32])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // An SOF beat is evaluated as pixel 0 of line 0 against the incoming cfg,
  // so 1x1 frames and mid-frame restarts share the normal beat path.
  always_comb begin
    beat        = s_axis_tvalid & s_axis_tready & cfg_enable;
    state_d     = state_q;
    pix_d       = pix_q;
    line_d      = line_q;
    proceed     = 1'b0;
    lane_init   = 1'b0;
    lane_update = 1'b0;
    latch_cfg   = 1'b0;
    frame_done  = 1'b0;
    set_sof     = 1'b0;
    set_early   = 1'b0;
    set_late    = 1'b0;
    cur_w       = width_q;
    cur_h       = height_q;
    base_pix    = pix_q;
    base_line   = line_q;
    pix_inc     = '0;
    if (clear) begin
      state_d = IDLE;
      pix_d   = '0;
      line_d  = '0;
    end else if (beat) begin
      unique case (state_q)
        IDLE:    proceed = s_axis_tuser;
        ACTIVE: begin
          proceed = 1'b1;
          set_sof = s_axis_tuser;
        end
        default: proceed = 1'b0;
      endcase
      if (proceed) begin
        if (s_axis_tuser) begin
          latch_cfg = 1'b1;
          lane_init = 1'b1;
          cur_w     = cfg_width;
          cur_h     = cfg_height;
          base_pix  = '0;
          base_line = '0;
        end else begin
          lane_update = 1'b1;
        end
        pix_inc   = {1'b0, base_pix} + (DIM_W+1)'(1);
        set_early = s_axis_tlast && (pix_inc < {1'b0, cur_w});
        set_late  = !s_axis_tlast && (pix_inc == {1'b0, cur_w});
        if (s_axis_tlast) begin
          pix_d = '0;
          if (base_line == cur_h - DIM_W'(1)) begin
            frame_done = 1'b1;
            state_d    = IDLE;
            line_d     = '0;
          end else begin
            state_d = ACTIVE;
            line_d  = base_line + DIM_W'(1);
          end
        end else begin
          state_d = ACTIVE;
          pix_d   = pix_inc[DIM_W-1:0];
          line_d  = base_line;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q         <= '0;
      height_q        <= '0;
      line_q          <= '0;
      pix_q           <= '0;
      crc_last        <= '0;
      crc_valid       <= 1'b0;
      frame_count     <= '0;
      stable_count    <= '0;
      mismatch_count  <= '0;
      golden_mismatch <= 1'b0;
      err_sof_early   <= 1'b0;
      err_eol_early   <= 1'b0;
      err_eol_late    <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      line_q    <= line_d;
      pix_q     <= pix_d;
      if (clear) begin
        width_q         <= '0;
        height_q        <= '0;
        crc_last        <= '0;
        frame_count     <= '0;
        stable_count    <= '0;
        mismatch_count  <= '0;
        golden_mismatch <= 1'b0;
        err_sof_early   <= 1'b0;
        err_eol_early   <= 1'b0;
        err_eol_late    <= 1'b0;
      end else begin
        if (latch_cfg) begin
          width_q  <= cfg_width;
          height_q <= cfg_height;
        end
        if (set_sof)   err_sof_early <= 1'b1;
        if (set_early) err_eol_early <= 1'b1;
        if (set_late)  err_eol_late  <= 1'b1;
        if (frame_done) begin
          crc_last    <= crc_next_all;
          crc_valid   <= 1'b1;
          frame_count <= frame_count + 32'd1;
          if (frame_count == '0 || crc_next_all != crc_last) begin
            stable_count <= 16'd1;
          end else if (stable_count != '1) begin
            stable_count <= stable_count + 16'd1;
          end
          if (cfg_golden_en && crc_next_all != cfg_golden) begin
            golden_mismatch <= 1'b1;
            if (mismatch_count != '1) mismatch_count <= mismatch_count + 16'd1;
          end
        end
      end
    end
  end

  assign line_count    = line_q;
  assign pixel_in_line = pix_q;

endmodule

// File: doc/video_stream_crc_monitor.md
Name: video_stream_crc_monitor

Overview:
- Passive, parametrised tap on an AXI-Stream video bus (tuser = SOF, tlast = EOL).
- Computes one CRC-32 per colour channel per frame and checks frame geometry against programmed width/height.
- Compares each frame against golden CRCs and tracks CRC stability across frames.
- Successor to the single-CRC HDMI monitor; used in-silicon and by regression benches to detect frame corruption without a host readback.

Parameters:
- DATA_W, 24: pixel beat width; must be divisible by CHANNELS.
- CHANNELS, 3: number of independent per-channel CRC lanes. Each lane covers CH_W = DATA_W/CHANNELS bits; lane 0 = LSBs.
- DIM_W, 16: width of the geometry counters and configuration fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- s_axis_tdata  in  DATA_W  observed pixel
- s_axis_tvalid  in  1  observed valid
- s_axis_tready  in  1  observed ready; monitor never drives it
- s_axis_tlast  in  1  end of line
- s_axis_tuser  in  1  start of frame
- cfg_enable  in  1  monitor enable
- cfg_width  in  DIM_W  pixels per line
- cfg_height  in  DIM_W  lines per frame
- cfg_golden  in  CHANNELS*32  expected CRC per lane
- cfg_golden_en  in  1  enable golden compare
- clear  in  1  one-cycle pulse that resets statistics
- crc_last  out  CHANNELS*32  CRCs of last complete frame
- crc_valid  out  1  one-cycle pulse when crc_last updates
- frame_count  out  32  complete frames, wraps
- line_count  out  DIM_W  current line index
- pixel_in_line  out  DIM_W  current pixel index
- stable_count  out  16  consecutive identical-CRC frames, saturating
- mismatch_count  out  16  golden mismatches, saturating
- golden_mismatch  out  1  sticky mismatch flag
- err_sof_early  out  1  sticky: SOF arrived mid-frame
- err_eol_early  out  1  sticky: tlast arrived before cfg_width pixels
- err_eol_late  out  1  sticky: cfg_width pixels passed without tlast

Behaviour:
- Reset: all outputs and internal state 0; state IDLE.
- Beat = s_axis_tvalid & s_axis_tready & cfg_enable. Nothing advances without a beat.
- CRC algorithm: CRC-32, poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first, no reflection, no final XOR. Each lane consumes its CH_W bits per beat.
- cfg_width and cfg_height are latched at SOF; changes mid-frame do not affect the current frame.
- IDLE:
  - Beat with tuser=1: latch cfg, seed lanes with init and fold in the beat, pixel_in_line=1, line_count=0, go to ACTIVE.
  - Beats with tuser=0 are ignored.
- ACTIVE, per beat:
  - tuser=1: set err_sof_early and abandon the frame (no crc_valid, no frame_count increment). Restart immediately as a fresh SOF with this beat.
  - tlast=1 with pixel_in_line+1 < width: set err_eol_early.
  - pixel_in_line+1 == width with tlast=0: set err_eol_late. Counting continues; pixel_in_line keeps incrementing.
  - tlast=1 on line height-1: frame complete, state returns to IDLE.
  - tlast=1 on any other line: line_count++, pixel_in_line=0.
- Frame complete (registered, exactly 1 cycle after the final beat):
  - crc_last takes the final lane CRCs; crc_valid pulses for 1 cycle; frame_count++.
  - stable_count: 1 if frame_count was 0 or any lane differs from the previous crc_last; otherwise increment, saturating at 0xFFFF.
  - If cfg_golden_en and any lane differs from cfg_golden: set golden_mismatch, mismatch_count++ (saturating).
- Width/height of 1 is legal: a single beat with tuser=1 and tlast=1 completes a 1x1 frame.
- A beat during the crc_valid cycle is processed normally; back-to-back frames need no gap.
- clear: zeroes counters, crc_last and sticky flags, returns to IDLE. If clear coincides with a beat, clear wins and the beat is dropped.
- cfg_enable low mid-frame freezes state; beats resume on re-enable.
- rst_n assertion mid-frame returns to reset values asynchronously.

Decomposition:
- video_crc_pkg holds:
  - CRC32_POLY and CRC32_INIT constants;
  - the state enum {IDLE, ACTIVE};
  - function crc32_update(crc, data, nbits), MSB-first bit loop.
- Sub-module video_crc32_lane: one CRC register with init/update/hold controls, instantiated CHANNELS times by generate.

Test Plan:
- ASCII CRC: DATA_W=8, CHANNELS=1, width=9, height=1; bytes "123456789" with tuser on the first and tlast on the last -> 1 cycle later crc_valid=1, crc_last=0x0376E6E7, frame_count=1.
- Stability: DATA_W=24, CHANNELS=3, 32x24; stream an identical ramp frame 3 times back-to-back -> frame_count=3, stable_count=3, no error flags. Corrupt 1 pixel in frame 4 -> only the affected lane's CRC changes, stable_count=1.
- Golden: cfg_golden_en=1 with cfg_golden equal to the first-test CRC; send the correct frame, then a frame with byte '5' changed -> mismatch_count=1, golden_mismatch=1 after frame 2 only.
- Geometry: width=4, height=2; tlast after pixel 3 on line 0 -> err_eol_early=1. Next frame has no tlast at pixel 4 -> err_eol_late=1. SOF inserted mid-line -> err_sof_early=1, frame_count unchanged.
- Clear/reset: clear pulsed on the same cycle as a beat mid-frame -> all counters 0, state IDLE, next tuser frame produces the correct CRC. rst_n low mid-frame -> all outputs 0 immediately.
- Backpressure: tready toggled every other cycle, plus cfg_enable low for 10 cycles mid-frame -> CRC identical to the unstalled run.
